demux_scheduler: RTL and testbench

DEMUX_SCHEDULER -- requirements
Module: demux_scheduler

---
 rtl/demux_scheduler.sv | 122 ++++++++++++
 tb/tb_demux_scheduler.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_scheduler.sv
// demux_scheduler: steers fixed-length frames of beats from one upstream
// stream onto one of two downstream channels. Channels are granted
// round-robin per frame, with a skip to the other channel when only it is
// ready. A one-beat output register decouples the channels from upstream.
module demux_scheduler #(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] Data_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] Data_out_0,
    output logic             valid_0,
    input  logic             ready_0,
    output logic [WIDTH-1:0] Data_out_1,
    output logic             valid_1,
    input  logic             ready_1,
    output logic             sel,
    output logic             frame_done
);

    typedef enum logic [1:0] {IDLE, SEND, DRAIN} state_t;

    localparam logic [7:0] LAST_BEAT = 8'(FRAME_LEN - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] obuf;
    logic             ovalid;
    logic [7:0]       bcnt;
    logic             last;
    logic             ready_sel;
    logic             take;
    logic             accept;
    logic             grant;
    logic             rdy_pref;
    logic             rdy_other;

    // Handshake terms for the channel that currently owns the frame.
    always_comb begin
        ready_sel = sel ? ready_1 : ready_0;
        take      = ovalid && ready_sel;
        accept    = in_valid && in_ready;
    end

    // Round-robin grant: prefer the channel not used last, unless only the
    // other one is ready right now.
    always_comb begin
        rdy_pref  = last ? ready_0 : ready_1;
        rdy_other = last ? ready_1 : ready_0;
        grant     = (!rdy_pref && rdy_other) ? last : ~last;
    end

    // Next-state and upstream ready.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) state_nxt = SEND;
            end
            SEND: begin
                in_ready = !ovalid || ready_sel;
                if (in_valid && in_ready && (bcnt == LAST_BEAT)) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (take) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Output register; cleared when emptied so idle outputs read zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            obuf   <= '0;
            ovalid <= 1'b0;
        end else if (accept) begin
            obuf   <= Data_in;
            ovalid <= 1'b1;
        end else if (take) begin
            obuf   <= '0;
            ovalid <= 1'b0;
        end
    end

    // Frame control: channel ownership, beat count, round-robin history.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel        <= 1'b0;
            last       <= 1'b1;
            bcnt       <= 8'd0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= (state == DRAIN) && take;
            if (state == IDLE && in_valid) begin
                sel  <= grant;
                bcnt <= 8'd0;
            end else if (accept) begin
                bcnt <= (bcnt == LAST_BEAT) ? 8'd0 : bcnt + 8'd1;
            end
            if (state == DRAIN && take) last <= sel;
        end
    end

    // Steering: only the owning channel sees the output register.
    always_comb begin
        valid_0    = ovalid && !sel;
        valid_1    = ovalid && sel;
        Data_out_0 = sel ? '0 : obuf;
        Data_out_1 = sel ? obuf : '0;
    end

endmodule

// File: tb/tb_demux_scheduler.sv
// Directed bench for demux_scheduler: one FRAME_LEN=4 instance and one
// FRAME_LEN=1 instance sharing stimulus.
module tb_demux_scheduler;

    logic       clk;
    logic       reset_n;
    logic [7:0] Data_in;
    logic       in_valid;
    logic       ready_0;
    logic       ready_1;

    logic       ir4, v0_4, v1_4, sel4, fd4;
    logic [7:0] d0_4, d1_4;
    logic       ir1, v0_1, v1_1, sel1, fd1;
    logic [7:0] d0_1, d1_1;

    logic       use1;
    logic       m_in_ready, m_valid_0, m_valid_1, m_sel, m_fd;
    logic [7:0] m_d0, m_d1;

    int n_assert = 0;
    int n_fail   = 0;
    int fd_cnt   = 0;
    int idle_bad = 0;

    logic [7:0] in_q[$];
    logic [7:0] out0[$];
    logic [7:0] out1[$];
    logic [7:0] sel_q[$];
    logic [7:0] exp_q[$];

    demux_scheduler #(.WIDTH(8), .FRAME_LEN(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .Data_in(Data_in), .in_valid(in_valid),
        .in_ready(ir4), .Data_out_0(d0_4), .valid_0(v0_4), .ready_0(ready_0),
        .Data_out_1(d1_4), .valid_1(v1_4), .ready_1(ready_1),
        .sel(sel4), .frame_done(fd4)
    );

    demux_scheduler #(.WIDTH(8), .FRAME_LEN(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .Data_in(Data_in), .in_valid(in_valid),
        .in_ready(ir1), .Data_out_0(d0_1), .valid_0(v0_1), .ready_0(ready_0),
        .Data_out_1(d1_1), .valid_1(v1_1), .ready_1(ready_1),
        .sel(sel1), .frame_done(fd1)
    );

    assign m_in_ready = use1 ? ir1  : ir4;
    assign m_valid_0  = use1 ? v0_1 : v0_4;
    assign m_valid_1  = use1 ? v1_1 : v1_4;
    assign m_d0       = use1 ? d0_1 : d0_4;
    assign m_d1       = use1 ? d1_1 : d1_4;
    assign m_sel      = use1 ? sel1 : sel4;
    assign m_fd       = use1 ? fd1  : fd4;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_q(input string tag, input logic [7:0] q[$], input logic [7:0] e[$]);
        chk({tag, "_len"}, 32'(q.size()), 32'(e.size()));
        for (int i = 0; i < e.size(); i++)
            chk($sformatf("%s[%0d]", tag, i), {24'd0, (i < q.size()) ? q[i] : 8'hxx}, {24'd0, e[i]});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        out0.delete(); out1.delete(); sel_q.delete();
        fd_cnt   = 0;
        idle_bad = 0;
    endtask

    // Push in_q through the selected DUT for n cycles and record what leaves.
    task automatic run(input int n);
        logic acc;
        for (int c = 0; c < n; c++) begin
            in_valid = (in_q.size() > 0);
            Data_in  = in_valid ? in_q[0] : 8'h00;
            #1;
            acc = in_valid && m_in_ready;
            if (m_valid_0 && ready_0) out0.push_back(m_d0);
            if (m_valid_1 && ready_1) out1.push_back(m_d1);
            if (m_fd) begin
                fd_cnt++;
                sel_q.push_back({7'd0, m_sel});
            end
            if (m_sel == 1'b0) begin
                if (m_valid_1 !== 1'b0 || m_d1 !== 8'h00) idle_bad++;
            end else begin
                if (m_valid_0 !== 1'b0 || m_d0 !== 8'h00) idle_bad++;
            end
            @(posedge clk);
            #1;
            if (acc) void'(in_q.pop_front());
        end
        in_valid = 1'b0;
        Data_in  = 8'h00;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"}, {31'd0, ir4}, 32'd0);
        chk({tag, "_valid"}, {30'd0, v0_4, v1_4}, 32'd0);
        chk({tag, "_data"}, {16'd0, d0_4, d1_4}, 32'd0);
        chk({tag, "_sel_fd"}, {30'd0, sel4, fd4}, 32'd0);
    endtask

    initial begin
        use1     = 1'b0;
        reset_n  = 1'b0;
        in_valid = 1'b1;
        Data_in  = 8'h5A;
        ready_0  = 1'b1;
        ready_1  = 1'b1;

        // Reset holds everything at zero even with traffic offered
        tick(); tick();
        chk_all_zero("reset");
        chk("reset_dut1", {26'd0, ir1, v0_1, v1_1, sel1, fd1, |(d0_1 | d1_1)}, 32'd0);
        in_valid = 1'b0;
        reset_n  = 1'b1;
        tick();

        // First cycle after release: IDLE never accepts
        in_valid = 1'b1;
        Data_in  = 8'h01;
        #1;
        chk("first_cycle_in_ready", {31'd0, ir4}, 32'd0);

        // Two frames alternate channels 0 then 1
        clear_obs();
        in_q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        run(20);
        exp_q = {8'h01, 8'h02, 8'h03, 8'h04}; chk_q("rr_ch0", out0, exp_q);
        exp_q = {8'h05, 8'h06, 8'h07, 8'h08}; chk_q("rr_ch1", out1, exp_q);
        chk("rr_frame_done", 32'(fd_cnt), 32'd2);
        exp_q = {8'h00, 8'h01}; chk_q("rr_sel", sel_q, exp_q);
        chk("rr_idle_zero", 32'(idle_bad), 32'd0);

        // Preferred channel 0 not ready at grant: skip to channel 1
        clear_obs();
        ready_0 = 1'b0;
        in_q = {8'h21, 8'h22, 8'h23, 8'h24};
        run(12);
        exp_q = {8'h21, 8'h22, 8'h23, 8'h24}; chk_q("skip_ch1", out1, exp_q);
        chk("skip_ch0_len", 32'(out0.size()), 32'd0);
        exp_q = {8'h01}; chk_q("skip_sel", sel_q, exp_q);

        // Following frame goes back to channel 0
        clear_obs();
        ready_0 = 1'b1;
        in_q = {8'h31, 8'h32, 8'h33, 8'h34};
        run(12);
        exp_q = {8'h31, 8'h32, 8'h33, 8'h34}; chk_q("after_skip_ch0", out0, exp_q);
        exp_q = {8'h00}; chk_q("after_skip_sel", sel_q, exp_q);

        // Backpressure on channel 0 mid-frame (preferred 1 skipped at grant)
        ready_0 = 1'b1; ready_1 = 1'b0;
        in_valid = 1'b1; Data_in = 8'h41;
        #1; chk("bp_idle_in_ready", {31'd0, ir4}, 32'd0);
        tick();
        #1; chk("bp_sel", {31'd0, sel4}, 32'd0);
        chk("bp_first_in_ready", {31'd0, ir4}, 32'd1);
        tick();
        Data_in = 8'h42;
        #1; chk("bp_latency", {23'd0, v0_4, d0_4}, {23'd0, 1'b1, 8'h41});
        tick();
        ready_0 = 1'b0; Data_in = 8'h43;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("bp_hold%0d", k), {23'd0, v0_4, d0_4}, {23'd0, 1'b1, 8'h42});
            chk($sformatf("bp_stall%0d", k), {31'd0, ir4}, 32'd0);
            tick();
        end
        ready_0 = 1'b1;
        #1; chk("bp_resume", {22'd0, ir4, v0_4, d0_4}, {22'd0, 1'b1, 1'b1, 8'h42});
        tick();
        Data_in = 8'h44;
        #1; chk("bp_next", {23'd0, v0_4, d0_4}, {23'd0, 1'b1, 8'h43});
        tick();
        in_valid = 1'b0;
        #1; chk("bp_last", {22'd0, ir4, v0_4, d0_4}, {22'd0, 1'b0, 1'b1, 8'h44});
        chk("bp_ch1_quiet", {23'd0, v1_4, d1_4}, 32'd0);
        tick();
        #1; chk("bp_done", {29'd0, fd4, v0_4, sel4}, {29'd0, 1'b1, 1'b0, 1'b0});
        tick();
        ready_1 = 1'b1;

        // Simultaneous take and accept: A0 then A1 back-to-back on channel 1
        in_valid = 1'b1; Data_in = 8'hA0;
        tick();
        #1; chk("ta_sel", {31'd0, sel4}, 32'd1);
        tick();
        Data_in = 8'hA1;
        #1; chk("ta_first", {22'd0, ir4, v1_4, d1_4}, {22'd0, 1'b1, 1'b1, 8'hA0});
        tick();
        in_valid = 1'b0;
        #1; chk("ta_second", {23'd0, v1_4, d1_4}, {23'd0, 1'b1, 8'hA1});
        tick();
        #1; chk("ta_empty", {22'd0, ir4, v1_4, d1_4}, {22'd0, 1'b1, 1'b0, 8'h00});

        // Reset after two beats of the frame clears outputs immediately
        reset_n = 1'b0;
        #1; chk_all_zero("midreset");
        tick();
        reset_n = 1'b1;
        tick();
        clear_obs();
        in_q = {8'h51, 8'h52, 8'h53, 8'h54};
        run(12);
        exp_q = {8'h51, 8'h52, 8'h53, 8'h54}; chk_q("post_reset_ch0", out0, exp_q);
        chk("post_reset_ch1_len", 32'(out1.size()), 32'd0);
        chk("post_reset_fd", 32'(fd_cnt), 32'd1);

        // FRAME_LEN=1: every beat is a frame, channels alternate
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        use1 = 1'b1;
        clear_obs();
        in_q = {8'h11, 8'h22, 8'h33};
        run(15);
        exp_q = {8'h11, 8'h33}; chk_q("fl1_ch0", out0, exp_q);
        exp_q = {8'h22};        chk_q("fl1_ch1", out1, exp_q);
        chk("fl1_fd", 32'(fd_cnt), 32'd3);
        exp_q = {8'h00, 8'h01, 8'h00}; chk_q("fl1_sel", sel_q, exp_q);
        chk("fl1_idle_zero", 32'(idle_bad), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
